// File: rtl/usb_tx_buf_pkg.sv
`timescale 1ns/1ps
// Shared widths and drain-FSM encoding for the USB transmit page buffer.
package usb_tx_buf_pkg;

  localparam int USB_DATA_NBIT = 16;
  localparam int USB_ADDR_NBIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SEND   = 2'd2,
    ST_PKTEND = 2'd3
  } tx_state_t;

  // Page 0 has priority when both pages are ready.
  function automatic logic sel_page(input logic [1:0] rdy);
    return ~rdy[0];
  endfunction

endpackage

// File: rtl/usb_tx_buf_if.sv
`timescale 1ns/1ps
// Command-side write bus plus USB slave-FIFO signals of the transmit buffer.
interface usb_tx_buf_if
  import usb_tx_buf_pkg::*;
#(
  parameter int P_DATA_NBIT = USB_DATA_NBIT,
  parameter int P_ADDR_NBIT = USB_ADDR_NBIT
);

  logic                   wr_vd;
  logic [P_ADDR_NBIT:0]   wr_addr;
  logic [P_DATA_NBIT-1:0] wr_data;
  logic                   wr_eop;
  logic                   usb_full_n;
  logic                   usb_wr_n;
  logic [P_DATA_NBIT-1:0] usb_dout;
  logic                   usb_pktend_n;
  logic [1:0]             page_rdy;
  logic                   ovf_err;

  modport master (
    output wr_vd, wr_addr, wr_data, wr_eop, usb_full_n,
    input  usb_wr_n, usb_dout, usb_pktend_n, page_rdy, ovf_err
  );

  modport slave (
    input  wr_vd, wr_addr, wr_data, wr_eop, usb_full_n,
    output usb_wr_n, usb_dout, usb_pktend_n, page_rdy, ovf_err
  );

endinterface

// File: rtl/usb_tx_dpram.sv
`timescale 1ns/1ps
// Simple dual-port page storage: one write port, one registered read port, no reset.
module usb_tx_dpram #(
  parameter int P_DATA_NBIT = 16,
  parameter int P_ADDR_NBIT = 9
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [P_ADDR_NBIT-1:0] i_waddr,
  input  logic [P_DATA_NBIT-1:0] i_wdata,
  input  logic                   i_re,
  input  logic [P_ADDR_NBIT-1:0] i_raddr,
  output logic [P_DATA_NBIT-1:0] o_rdata
);

  logic [P_DATA_NBIT-1:0] r_mem [0:(2**P_ADDR_NBIT)-1];
  logic [P_DATA_NBIT-1:0] r_rdata;

  // Read register only updates when enabled so the word holds through a stall.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/usb_tx_buf.sv
`timescale 1ns/1ps
// Two-page transmit buffer: pages are filled by the command decoder and
// drained word by word into the USB slave FIFO, followed by a packet-end strobe.
module usb_tx_buf
  import usb_tx_buf_pkg::*;
#(
  parameter int P_DATA_NBIT = USB_DATA_NBIT,
  parameter int P_ADDR_NBIT = USB_ADDR_NBIT
) (
  input  logic       mclk,
  input  logic       rst_n,
  usb_tx_buf_if.slave bus
);

  localparam logic [P_ADDR_NBIT-1:0] LP_LAST = '1;

  tx_state_t              r_state;
  logic                   r_page;
  logic [P_ADDR_NBIT-1:0] r_index;
  logic [1:0]             r_page_rdy;
  logic                   r_usb_wr_n;
  logic                   r_usb_pktend_n;
  logic [P_DATA_NBIT-1:0] r_usb_dout;
  logic                   r_ovf_err;

  logic                   w_wr_page;
  logic                   w_busy;
  logic                   w_we;
  logic                   w_re;
  logic [P_DATA_NBIT-1:0] w_rd_data;
  logic [1:0]             w_rdy_nxt;

  assign w_wr_page = bus.wr_addr[P_ADDR_NBIT];
  assign w_busy    = r_page_rdy[w_wr_page];
  assign w_we      = rst_n & bus.wr_vd & ~w_busy;
  assign w_re      = (r_state == ST_FETCH);

  usb_tx_dpram #(
    .P_DATA_NBIT (P_DATA_NBIT),
    .P_ADDR_NBIT (P_ADDR_NBIT + 1)
  ) u_dpram (
    .i_clk   (mclk),
    .i_we    (w_we),
    .i_waddr (bus.wr_addr),
    .i_wdata (bus.wr_data),
    .i_re    (w_re),
    .i_raddr ({r_page, r_index}),
    .o_rdata (w_rd_data)
  );

  // An eop to a page that is still being drained cannot collide with its clear:
  // that page is busy, so the eop is rejected as an overflow instead.
  always_comb begin
    w_rdy_nxt = r_page_rdy;
    if (r_state == ST_PKTEND) w_rdy_nxt[r_page] = 1'b0;
    if (bus.wr_eop && !w_busy) w_rdy_nxt[w_wr_page] = 1'b1;
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_page         <= 1'b0;
      r_index        <= '0;
      r_page_rdy     <= 2'b00;
      r_usb_wr_n     <= 1'b1;
      r_usb_pktend_n <= 1'b1;
      r_usb_dout     <= '0;
      r_ovf_err      <= 1'b0;
    end else begin
      r_usb_wr_n     <= 1'b1;
      r_usb_pktend_n <= 1'b1;
      r_ovf_err      <= w_busy & (bus.wr_vd | bus.wr_eop);
      r_page_rdy     <= w_rdy_nxt;
      case (r_state)
        ST_IDLE: begin
          if (|r_page_rdy) begin
            r_page  <= sel_page(r_page_rdy);
            r_index <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_SEND;
        ST_SEND: begin
          // Present the fetched word even while stalled; strobe only when the FIFO has room.
          r_usb_dout <= w_rd_data;
          if (bus.usb_full_n) begin
            r_usb_wr_n <= 1'b0;
            if (r_index == LP_LAST) begin
              r_state <= ST_PKTEND;
            end else begin
              r_index <= r_index + 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_PKTEND: begin
          r_usb_pktend_n <= 1'b0;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.usb_wr_n     = r_usb_wr_n;
  assign bus.usb_pktend_n = r_usb_pktend_n;
  assign bus.usb_dout     = r_usb_dout;
  assign bus.page_rdy     = r_page_rdy;
  assign bus.ovf_err      = r_ovf_err;

endmodule

// File: tb/tb_usb_tx_buf.sv
`timescale 1ns/1ps
// Scoreboard bench for usb_tx_buf: page snapshots queued at accepted eop, drained output checked by a monitor.
module tb_usb_tx_buf;
  import usb_tx_buf_pkg::*;

  localparam int NW = 256;

  typedef struct {
    bit          is_end;
    logic [15:0] d;
  } sb_t;

  logic mclk = 1'b0;
  logic rst_n;
  always #10 mclk = ~mclk;

  usb_tx_buf_if #(.P_DATA_NBIT(16), .P_ADDR_NBIT(8)) bus ();

  usb_tx_buf #(.P_DATA_NBIT(16), .P_ADDR_NBIT(8)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pkt_words = 0;
  int          first_cyc = 0;
  int          eop_cyc = 0;
  bit          mon_en = 0;
  bit          rand_full = 0;
  bit          exp_ovf_in = 0;
  bit          exp_ovf_q = 0;
  bit [1:0]    model_rdy = 2'b00;
  logic [15:0] model_mem [2][NW];
  sb_t         sb_q [$];
  bit          pg_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(posedge mclk) cyc <= cyc + 1;
  always @(posedge mclk) exp_ovf_q <= exp_ovf_in;

  // Monitor: every FIFO strobe must match the head of the expected stream.
  always @(negedge mclk) begin
    if (mon_en && rst_n) begin
      sb_t e;
      check("ovf_err", 32'(bus.ovf_err), 32'(exp_ovf_q));
      check("strobe_overlap", 32'(bus.usb_wr_n | bus.usb_pktend_n), 32'd1);
      if (!bus.usb_wr_n || !bus.usb_pktend_n) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: wr_n=%0b pktend_n=%0b with nothing expected", bus.usb_wr_n, bus.usb_pktend_n);
        end else begin
          e = sb_q.pop_front();
          if (!bus.usb_wr_n) begin
            check("word_not_pktend", 32'(e.is_end), 32'd0);
            if (!e.is_end) check("usb_dout", 32'(bus.usb_dout), 32'(e.d));
            if (pkt_words == 0) first_cyc = cyc;
            pkt_words++;
          end else begin
            check("pktend_position", 32'(e.is_end), 32'd1);
            check("pkt_len", 32'(pkt_words), 32'(NW));
            pkt_words = 0;
            if (pg_q.size() != 0) model_rdy[pg_q.pop_front()] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
    if (rand_full) bus.usb_full_n = ($urandom_range(0, 3) != 0);
  endtask

  task automatic accept_eop(input bit pg);
    sb_t e;
    for (int i = 0; i < NW; i++) begin
      e.is_end = 1'b0;
      e.d = model_mem[pg][i];
      sb_q.push_back(e);
    end
    e.is_end = 1'b1;
    e.d = '0;
    sb_q.push_back(e);
    pg_q.push_back(pg);
    model_rdy[pg] = 1'b1;
  endtask

  task automatic wr_word(input bit pg, input logic [7:0] idx, input logic [15:0] d, input bit eop);
    bus.wr_vd = 1'b1;
    bus.wr_addr = {pg, idx};
    bus.wr_data = d;
    bus.wr_eop = eop;
    exp_ovf_in = model_rdy[pg];
    if (!model_rdy[pg]) begin
      model_mem[pg][idx] = d;
      if (eop) accept_eop(pg);
    end
    tick();
    bus.wr_vd = 1'b0;
    bus.wr_eop = 1'b0;
    exp_ovf_in = 1'b0;
  endtask

  task automatic eop_only(input bit pg);
    bus.wr_eop = 1'b1;
    bus.wr_addr = {pg, 8'h00};
    exp_ovf_in = model_rdy[pg];
    if (!model_rdy[pg]) accept_eop(pg);
    eop_cyc = cyc;
    tick();
    bus.wr_eop = 1'b0;
    exp_ovf_in = 1'b0;
  endtask

  task automatic fill_rand(input bit pg);
    for (int i = 0; i < NW; i++) wr_word(pg, 8'(i), 16'($urandom), 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 4000), 32'd1);
    repeat (3) tick();
    check({name, "_page_rdy"}, 32'(bus.page_rdy), 32'd0);
  endtask

  task automatic wait_words(input int target, input string name);
    int n = 0;
    while (pkt_words < target && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    logic [15:0] w6;
    rst_n = 1'b0;
    bus.wr_vd = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_eop = 1'b0;
    bus.usb_full_n = 1'b1;
    repeat (3) tick();
    @(negedge mclk);
    check("rst_usb_wr_n", 32'(bus.usb_wr_n), 32'd1);
    check("rst_pktend_n", 32'(bus.usb_pktend_n), 32'd1);
    check("rst_usb_dout", 32'(bus.usb_dout), 32'd0);
    check("rst_page_rdy", 32'(bus.page_rdy), 32'd0);
    check("rst_ovf_err", 32'(bus.ovf_err), 32'd0);
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Known page, FIFO never full: data, latency and packet framing.
    for (int i = 0; i < NW; i++) wr_word(1'b0, 8'(i), 16'h0000, 1'b0);
    wr_word(1'b0, 8'd0, 16'h4024, 1'b0);
    wr_word(1'b0, 8'd1, 16'h3030, 1'b0);
    wr_word(1'b0, 8'd2, 16'h5030, 1'b0);
    wr_word(1'b0, 8'd3, 16'h3130, 1'b0);
    eop_only(1'b0);
    wait_drain("known_page");
    check("eop_to_first_strobe", 32'(first_cyc - eop_cyc), 32'd4);

    // Both pages filled, back-to-back eops, random FIFO back-pressure, overflow attempts.
    rand_full = 1'b1;
    fill_rand(1'b0);
    fill_rand(1'b1);
    eop_only(1'b0);
    eop_only(1'b1);
    repeat (5) tick();
    wr_word(1'b1, 8'd7, 16'hBEEF, 1'b0);
    eop_only(1'b1);
    wr_word(1'b0, 8'd9, 16'hCAFE, 1'b0);
    wait_drain("two_pages");

    // Fill page 0 while page 1 drains; stray writes/eops to page 1 overflow.
    for (int i = 0; i < NW - 1; i++) wr_word(1'b1, 8'(i), 16'($urandom), 1'b0);
    wr_word(1'b1, 8'hFF, 16'($urandom), 1'b1);
    for (int i = 0; i < NW; i++) begin
      if (i % 64 == 10) wr_word(1'b1, 8'(i), 16'($urandom), 1'b0);
      if (i == 100) eop_only(1'b1);
      wr_word(1'b0, 8'(i), 16'($urandom), 1'b0);
    end
    eop_only(1'b0);
    wait_drain("drain_while_fill");

    // FIFO full for 10 cycles after word 5.
    rand_full = 1'b0;
    bus.usb_full_n = 1'b1;
    fill_rand(1'b0);
    w6 = model_mem[0][6];
    eop_only(1'b0);
    wait_words(6, "stall_start");
    bus.usb_full_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge mclk);
      if (i >= 1) begin
        check("stall_dout", 32'(bus.usb_dout), 32'(w6));
        check("stall_wr_n", 32'(bus.usb_wr_n), 32'd1);
      end
    end
    tick();
    bus.usb_full_n = 1'b1;
    wait_drain("stall");

    // Reset in the middle of a drain, with a write/eop presented during reset.
    rand_full = 1'b1;
    fill_rand(1'b1);
    eop_only(1'b1);
    wait_words(100, "reset_point");
    rst_n = 1'b0;
    bus.wr_vd = 1'b1;
    bus.wr_addr = {1'b1, 8'h00};
    bus.wr_data = ~model_mem[1][0];
    bus.wr_eop = 1'b1;
    exp_ovf_in = 1'b0;
    tick();
    sb_q.delete();
    pg_q.delete();
    model_rdy = 2'b00;
    pkt_words = 0;
    @(negedge mclk);
    check("midrst_wr_n", 32'(bus.usb_wr_n), 32'd1);
    check("midrst_pktend_n", 32'(bus.usb_pktend_n), 32'd1);
    check("midrst_page_rdy", 32'(bus.page_rdy), 32'd0);
    check("midrst_ovf_err", 32'(bus.ovf_err), 32'd0);
    tick();
    bus.wr_vd = 1'b0;
    bus.wr_eop = 1'b0;
    rst_n = 1'b1;
    repeat (8) tick();
    check("post_rst_page_rdy", 32'(bus.page_rdy), 32'd0);
    eop_only(1'b1);
    wait_drain("after_reset");

    rand_full = 1'b0;
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
